// File: rtl/imem_responder.sv
// Responder for the stalling instruction/data memory port.
// Miss requests stall the requester for LATENCY cycles and then complete with a
// one-cycle Done. A one-entry buffer holding the last word read answers repeat
// reads in the same cycle. Malformed requests complete at once with err.
module imem_responder #(
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned MEM_WORDS_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int unsigned IdxW  = MEM_WORDS_LOG2;
  localparam int unsigned Depth = 1 << IdxW;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic              rd_q;
  logic              wr_q;
  logic [15:0]       wdata_q;
  logic              buf_valid_q;
  logic [IdxW-1:0]   buf_tag_q;
  logic [15:0]       buf_data_q;
  logic [15:0]       dout_q;

  logic [15:0]       mem [Depth];

  logic [IdxW-1:0]   idx;
  logic              req;
  logic              illegal;
  logic              in_idle;
  logic              is_err;
  logic              is_hit;
  logic              is_miss;
  logic [15:0]       mem_rdata;
  logic [15:0]       done_data;
  logic              unused_addr_hi;

  // Address bits above the word index alias onto the same word.
  assign idx            = Addr[IdxW:1];
  assign unused_addr_hi = ^(Addr >> (IdxW + 1));

  // Classify the request presented in IDLE; BUSY/DONE ignore Rd/Wr.
  always_comb begin
    req       = Rd | Wr;
    illegal   = req & ((Rd & Wr) | Addr[0]);
    in_idle   = (state_q == StIdle);
    is_err    = in_idle & illegal;
    is_hit    = in_idle & Rd & ~Wr & ~Addr[0] & buf_valid_q & (buf_tag_q == idx);
    is_miss   = in_idle & req & ~illegal & ~is_hit;
    mem_rdata = mem[idx_q];
    done_data = wr_q ? wdata_q : mem_rdata;
  end

  // Status outputs; forced low while reset is asserted so the held request
  // cannot produce Stall/err during reset.
  always_comb begin
    Done     = rst & (is_err | is_hit | (state_q == StDone));
    Stall    = rst & (is_miss | (state_q == StBusy));
    CacheHit = rst & is_hit;
    err      = rst & is_err;
    DataOut  = dout_q;
    if (rst && is_hit) begin
      DataOut = buf_data_q;
    end else if (rst && state_q == StDone) begin
      DataOut = done_data;
    end
  end

  // Request FSM, miss countdown and hit buffer maintenance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= 16'h0000;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= 16'h0000;
      dout_q      <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_hit) begin
            dout_q <= buf_data_q;
          end
          if (is_miss) begin
            idx_q   <= idx;
            rd_q    <= Rd;
            wr_q    <= Wr;
            wdata_q <= DataIn;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= (LATENCY == 1) ? StDone : StBusy;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          dout_q <= done_data;
          if (rd_q) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= idx_q;
            buf_data_q  <= mem_rdata;
          end else if (wr_q && buf_valid_q && (buf_tag_q == idx_q)) begin
            // Keep the buffered copy coherent with the store.
            buf_data_q <= wdata_q;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Backing store write; reset forces IDLE, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state_q == StDone && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
